// File: rtl/ahb_ram_slave.sv
// ahb_ram_slave: AHB-Lite slave in front of a word-organised on-chip RAM.
// It inserts a fixed number of wait states per transfer, supports byte-lane
// writes, and gives a two-cycle ERROR response to illegal transfers.
//
// state | meaning
// IDLE  | no data phase outstanding; ready for a new address phase
// WAIT  | legal transfer stalled; wait counter running down to 0
// DATA  | last data-phase cycle of a legal transfer; a write commits at its end
// ERR1  | first ERROR cycle (hreadyout low, hresp high)
// ERR2  | second ERROR cycle (hreadyout high, hresp high)
module ahb_ram_slave #(
  parameter int unsigned ADDR_BITS   = 12,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic [1:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic        hwrite,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic        hreadyout,
  output logic        hresp,
  output logic [31:0] hrdata
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_DATA = 3'd2,
    S_ERR1 = 3'd3,
    S_ERR2 = 3'd4
  } state_e;

  localparam int unsigned DEPTH    = 2 ** ADDR_BITS;
  localparam int unsigned WS_M1    = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
  localparam logic [3:0]  WS_LOAD  = 4'(WS_M1);
  localparam bit          HAS_WAIT = (WAIT_STATES > 0);

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [ADDR_BITS-1:0] idx_q;
  logic [1:0]           lane_q;
  logic [1:0]           size_q;
  logic                 write_q;
  logic [31:0]          mem_q [DEPTH];

  logic       accept;
  logic       size_ok;
  logic       align_ok;
  logic       range_ok;
  logic       legal;
  logic [3:0] be;
  logic       unused_ok;

  // Burst type and the BUSY/IDLE distinction carry no meaning here.
  assign unused_ok = ^{hburst, htrans[0]};

  // A new address phase only counts while this slave is itself ready, so
  // address-phase signals held by the master during a stall are ignored.
  assign accept = hsel & hready & htrans[1] & hreadyout;

  // Legality of the transfer being offered in the current address phase.
  assign size_ok  = (hsize != 2'b11);
  assign align_ok = (hsize == 2'b01) ? ~haddr[0] :
                    (hsize == 2'b10) ? (haddr[1:0] == 2'b00) : 1'b1;
  // The window is aligned to its size, so the upper address bits decide it.
  assign range_ok = (haddr[31:ADDR_BITS+2] == BASE_ADDR[31:ADDR_BITS+2]);
  assign legal    = size_ok & align_ok & range_ok;

  // State and wait-counter registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; IDLE, DATA and ERR2 all behave alike on a new accept.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE, S_DATA, S_ERR2: begin
        if (accept) begin
          if (!legal) begin
            state_d = S_ERR1;
          end else if (HAS_WAIT) begin
            state_d = S_WAIT;
            cnt_d   = WS_LOAD;
          end else begin
            state_d = S_DATA;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ERR1: begin
        state_d = S_ERR2;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Bus response outputs; read data is driven straight from the RAM array
  // so a write committed on the previous edge is visible immediately.
  always_comb begin
    hreadyout = 1'b1;
    hresp     = 1'b0;
    hrdata    = 32'h0;
    unique case (state_q)
      S_WAIT: begin
        hreadyout = 1'b0;
      end
      S_DATA: begin
        if (!write_q) hrdata = mem_q[idx_q];
      end
      S_ERR1: begin
        hreadyout = 1'b0;
        hresp     = 1'b1;
      end
      S_ERR2: begin
        hresp = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Latch the address-phase controls of every accepted transfer.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      idx_q   <= '0;
      lane_q  <= 2'b00;
      size_q  <= 2'b00;
      write_q <= 1'b0;
    end else if (accept) begin
      idx_q   <= haddr[ADDR_BITS+1:2];
      lane_q  <= haddr[1:0];
      size_q  <= hsize;
      write_q <= hwrite;
    end
  end

  // Byte-lane enables from the latched size and low address bits.
  always_comb begin
    be = 4'b0000;
    unique case (size_q)
      2'b00:   be = 4'b0001 << lane_q;
      2'b01:   be = lane_q[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  // RAM write port: commits on the edge that ends a write's DATA cycle.
  // Errored transfers never reach DATA, so they cannot write.
  always_ff @(posedge clk) begin
    if (state_q == S_DATA && write_q) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) mem_q[idx_q][8*k +: 8] <= hwdata[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ahb_ram_slave.sv
// Bench for ahb_ram_slave: three instances (0, 2 and 3 wait states) share
// one AHB master; only one instance is selected at a time. A transfer-level
// model predicts every cycle of every instance's outputs.
module tb_ahb_ram_slave;

  localparam int          NDUT  = 3;
  localparam int          ABITS = 12;
  localparam int          DEPTH = 2 ** ABITS;
  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam int          WSV [NDUT] = '{0, 2, 3};

  typedef struct {
    bit          sel;
    logic [31:0] addr;
    logic [1:0]  trans;
    logic [1:0]  size;
    bit          write;
    logic [31:0] wdata;
  } op_t;

  typedef struct {
    bit          rdy;
    bit          resp;
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [1:0]  size;
  } exp_t;

  logic        clk;
  logic        nrst;
  logic [2:0]  hsel_v;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic [1:0]  hsize;
  logic [2:0]  hburst;
  logic        hwrite;
  logic [31:0] hwdata;
  logic        hready_bus;
  logic [31:0] hrdata_bus;
  logic [1:0]  cur;

  logic [2:0]  rdy_w;
  logic [2:0]  resp_w;
  logic [31:0] rdata_w [NDUT];

  int ncmp = 0;
  int nerr = 0;

  op_t         ops [$];
  logic [31:0] rd_log [$];
  int          last_cycles;
  int          last_low;

  exp_t        expq [NDUT][$];
  logic [31:0] mmem [int];
  bit          known [int];

  assign hready_bus = rdy_w[cur];
  assign hrdata_bus = rdata_w[cur];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    ahb_ram_slave #(
      .ADDR_BITS(ABITS),
      .BASE_ADDR(BASE),
      .WAIT_STATES(WSV[g])
    ) dut (
      .clk      (clk),
      .nrst     (nrst),
      .hsel     (hsel_v[g]),
      .haddr    (haddr),
      .htrans   (htrans),
      .hsize    (hsize),
      .hburst   (hburst),
      .hwrite   (hwrite),
      .hwdata   (hwdata),
      .hready   (hready_bus),
      .hreadyout(rdy_w[g]),
      .hresp    (resp_w[g]),
      .hrdata   (rdata_w[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endfunction

  function automatic int mkey(int i, logic [31:0] a);
    return i * 1048576 + int'((a - BASE) >> 2);
  endfunction

  function automatic bit is_legal(logic [31:0] a, logic [1:0] sz);
    longint off;
    off = longint'({32'b0, a}) - longint'({32'b0, BASE});
    if (sz == 2'd3) return 1'b0;
    if (sz == 2'd1 && a[0]) return 1'b0;
    if (sz == 2'd2 && a[1:0] != 2'd0) return 1'b0;
    return (off >= 0) && (off < 4 * DEPTH);
  endfunction

  function automatic void model_write(int i, logic [31:0] a, logic [1:0] sz, logic [31:0] wd);
    int          key;
    logic [3:0]  lanes;
    logic [31:0] w;
    key = mkey(i, a);
    if (sz == 2'd0)      lanes = 4'b0001 << a[1:0];
    else if (sz == 2'd1) lanes = a[1] ? 4'b1100 : 4'b0011;
    else                 lanes = 4'b1111;
    if (lanes != 4'b1111 && !known.exists(key)) return;
    w = known.exists(key) ? mmem[key] : 32'h0;
    for (int k = 0; k < 4; k++) if (lanes[k]) w[8*k +: 8] = wd[8*k +: 8];
    mmem[key]  = w;
    known[key] = 1'b1;
  endfunction

  // Expected per-cycle outputs of the data phase following an accept.
  function automatic void push_transfer(int i);
    exp_t e;
    if (!is_legal(haddr, hsize)) begin
      e = '{rdy: 1'b0, resp: 1'b1, rd: 1'b0, wr: 1'b0, addr: 32'h0, size: 2'd0};
      expq[i].push_back(e);
      e.rdy = 1'b1;
      expq[i].push_back(e);
    end else begin
      for (int k = 0; k < WSV[i]; k++) begin
        e = '{rdy: 1'b0, resp: 1'b0, rd: 1'b0, wr: 1'b0, addr: 32'h0, size: 2'd0};
        expq[i].push_back(e);
      end
      e = '{rdy: 1'b1, resp: 1'b0, rd: !hwrite, wr: hwrite, addr: haddr, size: hsize};
      expq[i].push_back(e);
    end
  endfunction

  function automatic void cmp_cycle(int i);
    exp_t e;
    int   key;
    if (!nrst) begin
      expq[i].delete();
      chk($sformatf("dut%0d reset hreadyout", i), {31'b0, rdy_w[i]}, 32'd1);
      chk($sformatf("dut%0d reset hresp", i), {31'b0, resp_w[i]}, 32'd0);
      chk($sformatf("dut%0d reset hrdata", i), rdata_w[i], 32'h0);
      return;
    end
    if (expq[i].size() > 0) e = expq[i].pop_front();
    else e = '{rdy: 1'b1, resp: 1'b0, rd: 1'b0, wr: 1'b0, addr: 32'h0, size: 2'd0};
    chk($sformatf("dut%0d hreadyout", i), {31'b0, rdy_w[i]}, {31'b0, e.rdy});
    chk($sformatf("dut%0d hresp", i), {31'b0, resp_w[i]}, {31'b0, e.resp});
    if (e.rd) begin
      key = mkey(i, e.addr);
      if (known.exists(key)) chk($sformatf("dut%0d hrdata", i), rdata_w[i], mmem[key]);
    end else begin
      chk($sformatf("dut%0d hrdata idle", i), rdata_w[i], 32'h0);
    end
    if (e.wr) model_write(i, e.addr, e.size, hwdata);
    if (e.rdy && hsel_v[i] && htrans[1]) push_transfer(i);
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < NDUT; i++) cmp_cycle(i);
    end
  end

  function automatic op_t mk(bit sel, logic [31:0] a, logic [1:0] tr, logic [1:0] sz,
                             bit w, logic [31:0] wd);
    op_t o;
    o = '{sel: sel, addr: a, trans: tr, size: sz, write: w, wdata: wd};
    return o;
  endfunction

  task automatic drive_addr(op_t o);
    hsel_v = o.sel ? (3'b001 << cur) : 3'b000;
    haddr  = o.addr;
    htrans = o.trans;
    hsize  = o.size;
    hwrite = o.write;
    hburst = 3'($urandom);
  endtask

  task automatic drive_idle();
    hsel_v = 3'b000;
    haddr  = $urandom;
    htrans = 2'b00;
    hsize  = 2'($urandom);
    hwrite = 1'($urandom);
    hburst = 3'($urandom);
  endtask

  // Pipelined master: runs the queued ops on instance d; call at posedge+1.
  task automatic run_ops(input int d);
    op_t a, dp;
    bit  have_a, have_d, rdy;
    cur = 2'(d);
    last_cycles = 0;
    last_low    = 0;
    rd_log.delete();
    have_d = 1'b0;
    have_a = (ops.size() > 0);
    if (have_a) begin
      a = ops.pop_front();
      drive_addr(a);
    end
    while ((have_a || have_d) && last_cycles < 500) begin
      @(negedge clk);
      rdy = hready_bus;
      last_cycles++;
      if (!rdy) last_low++;
      if (rdy && have_d && dp.sel && dp.trans[1] && !dp.write) rd_log.push_back(hrdata_bus);
      @(posedge clk);
      #1;
      if (rdy) begin
        have_d = have_a;
        dp     = a;
        hwdata = have_d ? dp.wdata : $urandom;
        have_a = (ops.size() > 0);
        if (have_a) begin
          a = ops.pop_front();
          drive_addr(a);
        end else begin
          drive_idle();
        end
      end
    end
    if (last_cycles >= 500) begin
      ncmp++;
      nerr++;
      $display("FAIL run_ops timeout: got %0d cycles want < 500", last_cycles);
      ops.delete();
      drive_idle();
    end
  endtask

  task automatic check_log(string nm, int idx, logic [31:0] want);
    if (rd_log.size() > idx) chk(nm, rd_log[idx], want);
    else chk({nm, " (missing)"}, 32'hFFFF_FFFF, want);
  endtask

  task automatic random_ops(int n);
    op_t         o;
    logic [31:0] a;
    logic [1:0]  sz;
    int          r;
    for (int k = 0; k < n; k++) begin
      r  = $urandom_range(0, 9);
      a  = BASE + 32'($urandom_range(0, 31));
      if (r == 0) a = BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 15));
      if (r == 1) a = BASE - 32'd4;
      sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      o = mk($urandom_range(0, 9) != 0, a,
             ($urandom_range(0, 5) < 4) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1)),
             sz, 1'($urandom), $urandom);
      ops.push_back(o);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    nrst   = 1'b0;
    cur    = 2'd0;
    hwdata = 32'h0;
    drive_idle();
    repeat (3) @(posedge clk);
    #1;
    nrst = 1'b1;
    @(posedge clk);
    #1;

    // Zero wait states: write then pipelined read of the same word.
    ops.push_back(mk(1, BASE + 32'h10, 2'b10, 2'd2, 1, 32'hDEAD_BEEF));
    ops.push_back(mk(1, BASE + 32'h10, 2'b10, 2'd2, 0, 32'h0));
    run_ops(0);
    check_log("ws0 read after write", 0, 32'hDEAD_BEEF);
    chk("ws0 no stall", 32'(last_low), 32'd0);

    // Byte and halfword lane writes.
    ops.push_back(mk(1, BASE + 32'h10, 2'b10, 2'd2, 1, 32'h1122_3344));
    ops.push_back(mk(1, BASE + 32'h13, 2'b10, 2'd0, 1, 32'hAA00_0000));
    ops.push_back(mk(1, BASE + 32'h10, 2'b11, 2'd2, 0, 32'h0));
    ops.push_back(mk(1, BASE + 32'h12, 2'b10, 2'd1, 1, 32'h5566_0000));
    ops.push_back(mk(1, BASE + 32'h10, 2'b11, 2'd2, 0, 32'h0));
    run_ops(0);
    check_log("byte lane write", 0, 32'hAA22_3344);
    check_log("halfword lane write", 1, 32'h5566_3344);

    // Illegal transfers: misaligned, size 11, out of window; RAM untouched.
    ops.push_back(mk(1, BASE + 32'h2, 2'b10, 2'd2, 1, 32'hFFFF_FFFF));
    ops.push_back(mk(1, BASE + 32'h10, 2'b10, 2'd3, 1, 32'hFFFF_FFFF));
    ops.push_back(mk(1, BASE + 32'(4 * DEPTH), 2'b10, 2'd2, 1, 32'hFFFF_FFFF));
    ops.push_back(mk(1, BASE + 32'h10, 2'b10, 2'd2, 0, 32'h0));
    run_ops(0);
    chk("error stall cycles", 32'(last_low), 32'd3);
    check_log("read after errors", 0, 32'h5566_3344);
    chk("model word after lanes", mmem[mkey(0, BASE + 32'h10)], 32'h5566_3344);

    // No-access transfers.
    ops.push_back(mk(1, BASE + 32'h10, 2'b00, 2'd2, 0, 32'h0));
    ops.push_back(mk(0, BASE + 32'h10, 2'b10, 2'd2, 1, 32'h0BAD_0BAD));
    ops.push_back(mk(1, BASE + 32'h10, 2'b01, 2'd2, 1, 32'h0BAD_0BAD));
    run_ops(0);
    chk("idle no stall", 32'(last_low), 32'd0);
    chk("idle no reads", 32'(rd_log.size()), 32'd0);

    // Two wait states: single read, then a back-to-back pair.
    ops.push_back(mk(1, BASE + 32'h40, 2'b10, 2'd2, 1, 32'hCAFE_F00D));
    run_ops(1);
    ops.push_back(mk(1, BASE + 32'h40, 2'b10, 2'd2, 0, 32'h0));
    run_ops(1);
    chk("ws2 stall cycles", 32'(last_low), 32'd2);
    chk("ws2 data phase length", 32'(last_cycles - 1), 32'd3);
    check_log("ws2 read data", 0, 32'hCAFE_F00D);
    ops.push_back(mk(1, BASE + 32'h40, 2'b10, 2'd2, 0, 32'h0));
    ops.push_back(mk(1, BASE + 32'h40, 2'b10, 2'd2, 0, 32'h0));
    run_ops(1);
    chk("ws2 pair cycles", 32'(last_cycles - 1), 32'd6);

    // Three wait states: reset during WAIT drops the write.
    ops.push_back(mk(1, BASE + 32'h20, 2'b10, 2'd2, 1, 32'h0));
    run_ops(2);
    cur = 2'd2;
    drive_addr(mk(1, BASE + 32'h20, 2'b10, 2'd2, 1, 32'h0));
    @(posedge clk);
    #1;
    drive_idle();
    hwdata = 32'h1234_5678;
    @(posedge clk);
    #1;
    chk("ws3 in wait", {31'b0, rdy_w[2]}, 32'd0);
    nrst = 1'b0;
    #1;
    chk("async reset hreadyout", {31'b0, rdy_w[2]}, 32'd1);
    chk("async reset hresp", {31'b0, resp_w[2]}, 32'd0);
    chk("async reset hrdata", rdata_w[2], 32'h0);
    @(negedge clk);
    @(posedge clk);
    #1;
    nrst = 1'b1;
    ops.push_back(mk(1, BASE + 32'h20, 2'b10, 2'd2, 0, 32'h0));
    run_ops(2);
    check_log("write dropped by reset", 0, 32'h0);

    // Randomised traffic on every instance.
    for (int d = 0; d < NDUT; d++) begin
      for (int w = 0; w < 8; w++)
        ops.push_back(mk(1, BASE + 32'(4 * w), 2'b10, 2'd2, 1, $urandom));
      run_ops(d);
      random_ops(60);
      run_ops(d);
    end

    repeat (4) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/ahb_ram_slave.md
Name: ahb_ram_slave

Overview:
AHB-Lite slave that turns bus transfers into accesses to an on-chip word-organised RAM. It sits directly downstream of the core's AHB-Lite bus master and serves both instruction fetches and data loads/stores. Wait states are configurable, and sub-word writes use byte lanes. It gives an ERROR response for illegal transfers.

Parameters:
ADDR_BITS, 12, word-index width; RAM depth = 2^ADDR_BITS 32-bit words
BASE_ADDR, 32'h0000_0000, byte base address of the RAM window (aligned to its size)
WAIT_STATES, 0, extra data-phase cycles (hreadyout low) inserted per OKAY transfer; 0..15

Ports:
clk  input  1  system clock, rising edge
nrst  input  1  asynchronous active-low reset
hsel  input  1  slave select from the address decoder
haddr  input  32  byte address (address phase)
htrans  input  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
hsize  input  2  00 byte, 01 halfword, 10 word, 11 illegal
hburst  input  3  ignored; all transfers treated as single
hwrite  input  1  1 = write
hwdata  input  32  write data (data phase)
hready  input  1  bus-level ready (address phase accepted when high)
hreadyout  output  1  this slave's ready
hresp  output  1  0 OKAY, 1 ERROR
hrdata  output  32  read data, valid while hreadyout=1 in a read data phase

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (clk, nrst).
- Reset values: FSM=IDLE, hreadyout=1, hresp=0, hrdata=0, wait counter=0, latched address-phase registers cleared. RAM contents are not reset.
- Accept condition: an address phase is accepted on a rising edge with hsel & hready & htrans[1].
  - On accept, latch haddr, hsize and hwrite.
  - IDLE/BUSY transfers or hsel=0 cause no access. The following data phase then completes with zero wait and OKAY.
- Illegal transfers flag an error at accept. Any one of these is illegal:
  - hsize=11.
  - Misalignment: halfword with haddr[0]=1, or word with haddr[1:0]!=0.
  - haddr outside [BASE_ADDR, BASE_ADDR+4*2^ADDR_BITS).
- FSM states:
  - IDLE: hreadyout=1, hresp=0.
    - Legal accept with WAIT_STATES>0 -> WAIT, counter loaded with WAIT_STATES-1.
    - Legal accept with WAIT_STATES=0 -> DATA.
    - Illegal accept -> ERR1.
  - WAIT: hreadyout=0, hresp=0. Counter decrements; at 0 -> DATA.
  - DATA: hreadyout=1, hresp=0. The data phase completes this cycle.
    - A new legal/illegal accept in the same cycle goes to WAIT/DATA/ERR1 as from IDLE; otherwise -> IDLE.
  - ERR1: hreadyout=0, hresp=1 -> ERR2.
  - ERR2: hreadyout=1, hresp=1. A new accept is handled as from IDLE; otherwise -> IDLE.
- Latency: with WAIT_STATES=N, a legal data phase lasts N+1 cycles. Back-to-back pipelined transfers sustain 1 transfer per N+1 cycles.
- Read data path:
  - hrdata = RAM[latched word index] (combinational from the latched address) in DATA for reads; 0 otherwise.
  - Reads always return the full word regardless of hsize.
- Writes:
  - Committed on the rising edge ending DATA, using hwdata sampled on that edge.
  - Byte lanes:
    - Byte writes lane addr[1:0] with hwdata[8*k+7:8*k].
    - Halfword writes lanes {2a+1,2a} (a=addr[1]) from the matching hwdata bits.
    - Word writes all four lanes.
  - Unwritten lanes are unchanged. Errored or idle transfers never write.
- Read-after-write: a read accepted in the DATA cycle of a write to the same word returns the newly written data. This follows from the commit on that edge plus the combinational read from the latched address.
- Address-phase signals must be ignored while hreadyout=0, since the master holds them until ready.
- Reset mid-operation: FSM is forced to IDLE. An in-flight write is dropped (RAM untouched); an in-flight read is abandoned.
- Wait counter is ADDR-independent, 4 bits, and never wraps: it loads only on accept and stops at 0.

Test Plan:
- WAIT_STATES=0, word write 32'hDEADBEEF to BASE+0x10, then pipelined word read of the same address -> hreadyout never low, read DATA cycle hrdata=32'hDEADBEEF, hresp=0.
- Byte write 8'hAA to BASE+0x13 over word 32'h11223344, then word read -> 32'hAA223344. Halfword write 16'h5566 to BASE+0x12 -> read 32'h55663344.
- WAIT_STATES=2, word read -> hreadyout low exactly 2 cycles, then high 1 cycle with valid hrdata. A back-to-back pair takes 6 cycles.
- Word write to BASE+0x2 (misaligned), then hsize=11, then address BASE+4*2^ADDR_BITS -> each gives ERR1 (hreadyout=0, hresp=1) then ERR2 (hreadyout=1, hresp=1). The subsequent read shows the RAM unchanged.
- htrans=IDLE with hsel=1, and htrans=NONSEQ with hsel=0 -> no access, hreadyout=1, hresp=0, hrdata=0.
- WAIT_STATES=3, assert nrst low during WAIT of a write to BASE+0x20 holding 32'h0 -> outputs return to reset values immediately. After release, a read of BASE+0x20 returns 32'h0.
